// File: rtl/ctl_shot_scorer_if.sv
// rtl/ctl_shot_scorer_if.sv - shot/hit inputs and scoring outputs of the shot scorer
// master: the light-gun front end that drives shot/hit and duck events.
// slave : the scorer itself.
interface ctl_shot_scorer_if;
    logic        shot_fired;
    logic        hit;
    logic        miss;
    logic        duck_start;
    logic        game_clear;
    logic [1:0]  ammo;
    logic [13:0] score;
    logic        hit_pulse;
    logic        miss_pulse;
    logic        out_of_ammo;
    logic [3:0]  ducks_hit;

    modport master (
        output shot_fired, hit, miss, duck_start, game_clear,
        input  ammo, score, hit_pulse, miss_pulse, out_of_ammo, ducks_hit
    );

    modport slave (
        input  shot_fired, hit, miss, duck_start, game_clear,
        output ammo, score, hit_pulse, miss_pulse, out_of_ammo, ducks_hit
    );
endinterface

// File: rtl/ctl_shot_scorer.sv
// rtl/ctl_shot_scorer.sv - light-gun shot judging, ammo and score keeping
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of ctl_shot_scorer_if
//          in : shot_fired, hit, miss (level), duck_start, game_clear (pulses)
//          out: ammo, score, hit_pulse, miss_pulse, out_of_ammo, ducks_hit (all registered)
module ctl_shot_scorer #(
    parameter int AMMO_MAX  = 3,
    parameter int EVAL_WIN  = 4,
    parameter int HOLDOFF   = 8,
    parameter int POINTS    = 100,
    parameter int SCORE_MAX = 9999
) (
    input  logic                 clk,
    input  logic                 rst,
    ctl_shot_scorer_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        EVAL  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] WIN_LOAD  = CNT_W'(EVAL_WIN - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);
    localparam logic [1:0]       AMMO_LOAD = 2'(AMMO_MAX);
    localparam logic [14:0]      SCORE_CAP = 15'(SCORE_MAX);
    localparam logic [14:0]      SCORE_ADD = 15'(POINTS);

    state_t           state_q, state_d;
    logic [1:0]       ammo_q, ammo_d;
    logic [13:0]      score_q, score_d;
    logic [3:0]       ducks_q, ducks_d;
    logic             hit_pulse_q, hit_pulse_d;
    logic             miss_pulse_q, miss_pulse_d;
    logic             ooa_q, ooa_d;
    logic             duck_hit_q, duck_hit_d;
    logic             shot_prev_q;
    logic [CNT_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic             shot_edge;
    logic             hit_credit;
    logic [14:0]      score_sum;

    // The miss level is informational only; judgement comes from the window timeout.
    logic unused_miss;
    assign unused_miss = bus.miss;

    assign shot_edge = bus.shot_fired & ~shot_prev_q;
    assign score_sum = {1'b0, score_q} + SCORE_ADD;

    always_comb begin
        state_d      = state_q;
        ammo_d       = ammo_q;
        score_d      = score_q;
        ducks_d      = ducks_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        duck_hit_d   = duck_hit_q;
        win_d        = win_q;
        hold_d       = hold_q;
        hit_credit   = 1'b0;

        if (bus.duck_start) begin
            // A new duck overrides everything, including a pending judgement.
            state_d    = ARMED;
            ammo_d     = AMMO_LOAD;
            duck_hit_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ARMED: begin
                    if (shot_edge && (ammo_q != 2'd0)) begin
                        ammo_d  = ammo_q - 2'd1;
                        win_d   = WIN_LOAD;
                        state_d = EVAL;
                    end
                end
                EVAL: begin
                    if (bus.hit) begin
                        hit_pulse_d = 1'b1;
                        duck_hit_d  = 1'b1;
                        hit_credit  = 1'b1;
                        hold_d      = HOLD_LOAD;
                        state_d     = HOLD;
                    end else if (win_q == '0) begin
                        miss_pulse_d = 1'b1;
                        hold_d       = HOLD_LOAD;
                        state_d      = HOLD;
                    end else begin
                        win_d = win_q - CNT_W'(1);
                    end
                end
                HOLD: begin
                    // Stay for the full holdoff, then also until the trigger is released.
                    if (hold_q != '0) begin
                        hold_d = hold_q - CNT_W'(1);
                    end else if (!bus.shot_fired) begin
                        state_d = duck_hit_q ? IDLE : ARMED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (hit_credit) begin
            score_d = (score_sum > SCORE_CAP) ? SCORE_CAP[13:0] : score_sum[13:0];
            ducks_d = (ducks_q == 4'hF) ? 4'hF : ducks_q + 4'd1;
        end

        // Clear beats a simultaneous hit credit.
        if (bus.game_clear) begin
            score_d = '0;
            ducks_d = '0;
        end

        // Computed from next-state values so the registered flag lines up with ammo/state.
        ooa_d = (ammo_d == 2'd0) && !duck_hit_d && ((state_d == ARMED) || (state_d == IDLE));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ammo_q       <= 2'd0;
            score_q      <= '0;
            ducks_q      <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            ooa_q        <= 1'b1;
            duck_hit_q   <= 1'b0;
            shot_prev_q  <= 1'b0;
            win_q        <= '0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            ammo_q       <= ammo_d;
            score_q      <= score_d;
            ducks_q      <= ducks_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            ooa_q        <= ooa_d;
            duck_hit_q   <= duck_hit_d;
            shot_prev_q  <= bus.shot_fired;
            win_q        <= win_d;
            hold_q       <= hold_d;
        end
    end

    assign bus.ammo        = ammo_q;
    assign bus.score       = score_q;
    assign bus.ducks_hit   = ducks_q;
    assign bus.hit_pulse   = hit_pulse_q;
    assign bus.miss_pulse  = miss_pulse_q;
    assign bus.out_of_ammo = ooa_q;

endmodule

// File: tb/tb_ctl_shot_scorer.sv
// tb/tb_ctl_shot_scorer.sv - self-checking bench for ctl_shot_scorer
module tb_ctl_shot_scorer;

    localparam int AMMO_MAX  = 3;
    localparam int EVAL_WIN  = 4;
    localparam int HOLDOFF   = 8;
    localparam int POINTS    = 100;
    localparam int SCORE_MAX = 9999;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctl_shot_scorer_if bus ();

    ctl_shot_scorer #(
        .AMMO_MAX (AMMO_MAX),
        .EVAL_WIN (EVAL_WIN),
        .HOLDOFF  (HOLDOFF),
        .POINTS   (POINTS),
        .SCORE_MAX(SCORE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model (timestamp based) ----------------
    int m_cyc;
    int m_ammo, m_score, m_ducks;
    bit m_flag, m_ready, m_prev, m_hp, m_mp;
    int m_shot;   // cycle of the accepted shot awaiting judgement, -1 if none
    int m_judge;  // cycle of the last judgement while still holding off, -1 if none

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ammo = 0; m_score = 0; m_ducks = 0;
            m_flag = 0; m_ready = 0; m_prev = 0; m_hp = 0; m_mp = 0;
            m_shot = -1; m_judge = -1; m_cyc = 0;
        end else begin
            bit edge_seen, credit;
            m_cyc++;
            edge_seen = bus.shot_fired && !m_prev;
            credit = 0;
            m_hp = 0; m_mp = 0;
            if (bus.duck_start) begin
                m_ammo = AMMO_MAX; m_flag = 0; m_ready = 1; m_shot = -1; m_judge = -1;
            end else if (m_shot >= 0) begin
                if (bus.hit) begin
                    m_hp = 1; m_flag = 1; credit = 1; m_judge = m_cyc; m_shot = -1;
                end else if (m_cyc - m_shot == EVAL_WIN) begin
                    m_mp = 1; m_judge = m_cyc; m_shot = -1;
                end
            end else if (m_judge >= 0) begin
                if (m_cyc - m_judge >= HOLDOFF && !bus.shot_fired) begin
                    m_judge = -1; m_ready = !m_flag;
                end
            end else if (m_ready && edge_seen && m_ammo > 0) begin
                m_ammo--; m_shot = m_cyc;
            end
            if (credit) begin
                m_score = (m_score + POINTS > SCORE_MAX) ? SCORE_MAX : m_score + POINTS;
                m_ducks = (m_ducks >= 15) ? 15 : m_ducks + 1;
            end
            if (bus.game_clear) begin
                m_score = 0; m_ducks = 0;
            end
            m_prev = bus.shot_fired;
        end
    end

    function automatic int model_ooa();
        return (m_ammo == 0 && !m_flag && m_shot < 0 && m_judge < 0) ? 1 : 0;
    endfunction

    // ---------------- compare + pulse bookkeeping ----------------
    int  tcyc = 0;
    bit  cmp_en = 0;
    int  hp_cnt = 0, mp_cnt = 0, hp_last = 0, mp_last = 0;

    always @(posedge clk) tcyc++;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ammo",        int'(bus.ammo),        m_ammo);
            check("score",       int'(bus.score),       m_score);
            check("ducks_hit",   int'(bus.ducks_hit),   m_ducks);
            check("hit_pulse",   int'(bus.hit_pulse),   int'(m_hp));
            check("miss_pulse",  int'(bus.miss_pulse),  int'(m_mp));
            check("out_of_ammo", int'(bus.out_of_ammo), model_ooa());
            if (bus.hit_pulse)  begin hp_cnt++; hp_last = tcyc; end
            if (bus.miss_pulse) begin mp_cnt++; mp_last = tcyc; end
        end
    end

    // ---------------- stimulus helpers ----------------
    int shot_set, hit_set, hp0, mp0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic new_duck();
        bus.duck_start = 1'b1; tick();
        bus.duck_start = 1'b0; tick();
    endtask

    task automatic shoot(input int hold);
        bus.shot_fired = 1'b1; shot_set = tcyc;
        ticks(hold);
        bus.shot_fired = 1'b0;
    endtask

    task automatic hit_duck();
        new_duck();
        bus.shot_fired = 1'b1; tick();
        bus.hit = 1'b1; tick();
        bus.hit = 1'b0; bus.shot_fired = 1'b0;
        ticks(12);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ammo"},  int'(bus.ammo), 0);
        check({tag, "_score"}, int'(bus.score), 0);
        check({tag, "_ducks"}, int'(bus.ducks_hit), 0);
        check({tag, "_hp"},    int'(bus.hit_pulse), 0);
        check({tag, "_mp"},    int'(bus.miss_pulse), 0);
        check({tag, "_ooa"},   int'(bus.out_of_ammo), 1);
    endtask

    initial begin
        bus.shot_fired = 0; bus.hit = 0; bus.miss = 0;
        bus.duck_start = 0; bus.game_clear = 0;
        #1 rst = 1'b0;
        cmp_en = 1;
        ticks(3);
        check_reset_values("reset");
        rst = 1'b1;
        tick();

        // single hit, 2 cycles after the shot edge
        new_duck();
        bus.shot_fired = 1'b1; tick();
        tick();
        bus.hit = 1'b1; hit_set = tcyc; tick();
        bus.hit = 1'b0; bus.shot_fired = 1'b0;
        ticks(12);
        check("s1_hp_count", hp_cnt, 1);
        check("s1_hit_latency", hp_last - hit_set, 1);
        check("s1_ammo", int'(bus.ammo), 2);
        check("s1_score", int'(bus.score), 100);
        check("s1_ducks", int'(bus.ducks_hit), 1);
        shoot(2); ticks(8);
        check("s1_idle_ignores_shot", int'(bus.ammo), 2);

        // three misses, fourth edge ignored
        mp0 = mp_cnt;
        new_duck();
        for (int i = 0; i < 3; i++) begin
            shoot(2); ticks(18);
            check("s2_miss_latency", mp_last - shot_set, EVAL_WIN + 1);
        end
        check("s2_miss_count", mp_cnt - mp0, 3);
        check("s2_ammo", int'(bus.ammo), 0);
        check("s2_ooa", int'(bus.out_of_ammo), 1);
        shoot(2); ticks(15);
        check("s2_fourth_ignored", mp_cnt - mp0, 3);

        // trigger held 50 cycles, then a re-press inside holdoff
        mp0 = mp_cnt; hp0 = hp_cnt;
        new_duck();
        shoot(50); ticks(12);
        check("s3_one_pulse", (mp_cnt - mp0) + (hp_cnt - hp0), 1);
        check("s3_ammo", int'(bus.ammo), 2);
        shoot(2); ticks(4);
        shoot(2); ticks(15);
        check("s3_repress_ignored", int'(bus.ammo), 1);
        check("s3_pulses", (mp_cnt - mp0) + (hp_cnt - hp0), 2);

        // duck_start during EVAL, hit one cycle later
        hp0 = hp_cnt;
        new_duck();
        bus.shot_fired = 1'b1; tick();
        bus.duck_start = 1'b1; tick();
        bus.duck_start = 1'b0; bus.hit = 1'b1; tick();
        bus.hit = 1'b0; bus.shot_fired = 1'b0;
        ticks(10);
        check("s4_no_hit", hp_cnt - hp0, 0);
        check("s4_ammo", int'(bus.ammo), 3);
        shoot(2); ticks(3);
        check("s4_armed", int'(bus.ammo), 2);
        ticks(15);

        // game_clear coincident with hit judgement
        new_duck();
        bus.shot_fired = 1'b1; tick();
        bus.hit = 1'b1; bus.game_clear = 1'b1; tick();
        bus.hit = 1'b0; bus.game_clear = 1'b0; bus.shot_fired = 1'b0;
        ticks(12);
        check("s5_score_cleared", int'(bus.score), 0);
        check("s5_ducks_cleared", int'(bus.ducks_hit), 0);

        // score saturation
        for (int i = 0; i < 99; i++) hit_duck();
        check("s6_score_9900", int'(bus.score), 9900);
        check("s6_ducks_sat", int'(bus.ducks_hit), 15);
        hit_duck();
        check("s6_score_sat", int'(bus.score), 9999);
        hit_duck();
        check("s6_score_stays", int'(bus.score), 9999);

        // reset during EVAL discards the shot
        hp0 = hp_cnt; mp0 = mp_cnt;
        new_duck();
        bus.shot_fired = 1'b1; tick();
        tick();
        rst = 1'b0; ticks(2);
        bus.shot_fired = 1'b0; rst = 1'b1;
        ticks(10);
        check("s7_no_pulse", (hp_cnt - hp0) + (mp_cnt - mp0), 0);
        check("s7_ammo", int'(bus.ammo), 0);

        // reset mid-HOLD, then duck_start needed to arm
        new_duck();
        bus.shot_fired = 1'b1; tick();
        bus.hit = 1'b1; tick();
        bus.hit = 1'b0; bus.shot_fired = 1'b0;
        ticks(3);
        rst = 1'b0; tick();
        check_reset_values("s8");
        rst = 1'b1; tick();
        hp0 = hp_cnt; mp0 = mp_cnt;
        shoot(2); ticks(10);
        check("s8_not_armed", int'(bus.ammo), 0);
        check("s8_no_pulse", (hp_cnt - hp0) + (mp_cnt - mp0), 0);
        new_duck();
        check("s8_reload", int'(bus.ammo), 3);
        shoot(2); ticks(3);
        check("s8_armed", int'(bus.ammo), 2);
        ticks(15);

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ctl_shot_scorer.md
CTL_SHOT_SCORER -- requirements
Module: ctl_shot_scorer

Interface
REQ-001 The block SHALL provide these parameters:
- AMMO_MAX, 3: shots allowed per duck.
- EVAL_WIN, 4: cycles in which a hit is accepted after the shot edge.
- HOLDOFF, 8: minimum cycles between accepted shots.
- POINTS, 100: score added per hit.
- SCORE_MAX, 9999: score saturation value.

REQ-002 The block SHALL have one clock, clk; reset rst is asynchronous and active-low.

REQ-003 The block SHALL provide these ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- rst, in, 1: asynchronous active-low reset.
- shot_fired, in, 1: level, high while trigger or left button is held.
- hit, in, 1: level, high while shot is active and on target.
- miss, in, 1: level, high while shot is active and off target.
- duck_start, in, 1: one-cycle pulse, new duck presented, reload ammo.
- game_clear, in, 1: one-cycle pulse, zero score and counters.
- ammo, out, 2: remaining shots.
- score, out, 14: binary score.
- hit_pulse, out, 1: one-cycle pulse, shot judged hit.
- miss_pulse, out, 1: one-cycle pulse, shot judged miss.
- out_of_ammo, out, 1: level, ammo is 0 and no hit was scored on this duck.
- ducks_hit, out, 4: ducks hit since game_clear, saturating at 15.

Function
REQ-004 The FSM SHALL have states IDLE, ARMED, EVAL and HOLD; it SHALL enter IDLE on reset.

REQ-005 A shot edge SHALL be defined as shot_fired high this cycle and low in the previous registered sample.

REQ-006 In IDLE, duck_start SHALL load ammo to AMMO_MAX, clear the duck-hit flag, and move to ARMED on the next cycle.

REQ-007 In ARMED, a shot edge with ammo greater than 0 SHALL decrement ammo by 1, load the window counter with EVAL_WIN-1, and enter EVAL.

REQ-008 In ARMED, a shot edge with ammo equal to 0 SHALL be ignored: no pulse and no state change.

REQ-009 In EVAL, the first cycle with hit high SHALL assert hit_pulse in the next cycle, add POINTS to score (saturating at SCORE_MAX), set the duck-hit flag, increment ducks_hit (saturating), and enter HOLD.

REQ-010 In EVAL, if the window counter reaches 0 with no hit seen, miss_pulse SHALL be asserted for one cycle and the FSM SHALL enter HOLD; miss is informational only and is not required.

REQ-011 Exactly one of hit_pulse or miss_pulse SHALL be generated per accepted shot; they SHALL never be asserted together.

REQ-012 HOLD SHALL last at least HOLDOFF cycles and until shot_fired is low. It SHALL then return to IDLE if the duck-hit flag is set, otherwise to ARMED.

REQ-013 out_of_ammo SHALL be high when ammo is 0, the duck-hit flag is clear, and the FSM is in ARMED or IDLE.

REQ-014 duck_start received in ARMED, EVAL or HOLD SHALL reload ammo, clear the duck-hit flag, and force ARMED. A pending evaluation SHALL be discarded with no pulse.

REQ-015 game_clear SHALL zero score and ducks_hit in the next cycle. If it coincides with a hit judgement, the clear SHALL win.

REQ-016 Shot edges occurring in EVAL or HOLD SHALL be ignored.

REQ-017 All outputs SHALL be registered; the latency from the hit-qualifying cycle to hit_pulse SHALL be 1 cycle.

Reset
REQ-018 While rst is low, the block SHALL asynchronously set ammo=0, score=0, ducks_hit=0, hit_pulse=0, miss_pulse=0, out_of_ammo=1, FSM=IDLE, duck-hit flag=0, and previous shot sample=0.

REQ-019 Assertion of rst during EVAL SHALL discard the shot with no pulse after release.

REQ-020 Deassertion of rst SHALL take effect on the next clk edge; no output SHALL change before the first post-reset clock.

Verification
REQ-021 Case: duck_start, then a shot edge with hit high 2 cycles later -> ammo 3 to 2, one hit_pulse, score=100, ducks_hit=1, FSM returns to IDLE after release plus HOLDOFF.

REQ-022 Case: duck_start, then three shot edges spaced more than HOLDOFF apart, hit always low -> three miss_pulses, each EVAL_WIN cycles after its edge; ammo=0; out_of_ammo=1; a fourth edge is ignored.

REQ-023 Case: trigger held high for 50 cycles -> exactly one accepted shot and one pulse; a second edge inside HOLDOFF is ignored.

REQ-024 Case: score preset near 9950 via repeated hits, then one more hit -> score=9999, no wrap.

REQ-025 Case: duck_start arrives during EVAL with hit arriving 1 cycle later -> no hit_pulse, ammo=3, FSM=ARMED.

REQ-026 Case: rst asserted mid-HOLD, then released -> all outputs at reset values, and the FSM needs duck_start to arm.
